// File: rtl/alu_pkg.sv
// alu_pkg -- definitions shared by the alu_driver slice.
//   WIDTH_DEFAULT : operand/result width that the alu supports (16).
//   SIGN..OVF     : bit positions inside the 5-bit flag vector, which reads
//                   {overflow, parity, carry, zero, sign} from MSB to LSB.
//   drv_state_e   : driver FSM states.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int FLAG_W        = 5;

  localparam int SIGN   = 0;
  localparam int ZERO   = 1;
  localparam int CARRY  = 2;
  localparam int PARITY = 3;
  localparam int OVF    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } drv_state_e;

endpackage

// File: rtl/alu.sv
// alu -- combinational adder with status flags.
// Ports:
//   x, y  : operands (WIDTH bits)
//   sum   : x + y modulo 2^WIDTH
//   flags : {overflow, parity, carry, zero, sign}, indexed by alu_pkg
//           SIGN/ZERO/CARRY/PARITY/OVF
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  output logic [WIDTH-1:0]  sum,
  output logic [FLAG_W-1:0] flags
);

  // One extra bit captures the unsigned carry out.
  logic [WIDTH:0] full_sum;

  assign full_sum = {1'b0, x} + {1'b0, y};
  assign sum      = full_sum[WIDTH-1:0];

  always_comb begin
    flags         = '0;
    flags[SIGN]   = sum[WIDTH-1];
    flags[ZERO]   = (sum == '0);
    flags[CARRY]  = full_sum[WIDTH];
    // Parity flag is set for an even count of ones, hence the inverted XOR.
    flags[PARITY] = ~^sum;
    // Signed overflow: operands agree in sign but the result does not.
    flags[OVF]    = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
  end

endmodule

// File: rtl/alu_driver.sv
// alu_driver -- valid/ready wrapper that registers an operand pair, lets the
// combinational alu evaluate it for one cycle and holds the registered
// result until the consumer takes it.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake, operands on in_x/in_y
//   out_valid/out_ready   : result handshake, result on out_sum/out_flags
//                           (flags = {overflow, parity, carry, zero, sign})
//   busy                  : FSM is not in IDLE
// Optional build macro ALU_DRV_STICKY_EN adds:
//   clr_sticky            : clear the sticky accumulator at the next edge
//   sticky_flags          : {overflow, carry} ORed over every result
module alu_driver
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_x,
  input  logic [WIDTH-1:0]  in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic [FLAG_W-1:0] out_flags,
`ifdef ALU_DRV_STICKY_EN
  input  logic              clr_sticky,
  output logic [1:0]        sticky_flags,
`endif
  output logic              busy
);

  drv_state_e        state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              valid_q, valid_d;

  logic [WIDTH-1:0]  alu_sum;
  logic [FLAG_W-1:0] alu_flags;

  alu #(.WIDTH(WIDTH)) u_alu (
    .x     (x_q),
    .y     (y_q),
    .sum   (alu_sum),
    .flags (alu_flags)
  );

  // In HOLD a new pair can only be taken when the result leaves on the same
  // edge, so readiness follows the consumer.
  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sum_d   = sum_q;
    flags_d = flags_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          y_d     = in_y;
          state_d = EVAL;
        end
      end
      EVAL: begin
        sum_d   = alu_sum;
        flags_d = alu_flags;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (in_valid) begin
            x_d     = in_x;
            y_d     = in_y;
            state_d = EVAL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sum_q   <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sum_q   <= sum_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_flags = flags_q;
  assign busy      = (state_q != IDLE);

`ifdef ALU_DRV_STICKY_EN
  logic [1:0] sticky_q, sticky_d;

  // Clear happens first so a result landing in the same cycle survives it.
  always_comb begin
    sticky_d = clr_sticky ? 2'b00 : sticky_q;
    if (state_q == EVAL) begin
      sticky_d = sticky_d | {alu_flags[OVF], alu_flags[CARRY]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 2'b00;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver -- directed self-checking bench for alu_driver.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Build with ALU_DRV_STICKY_EN defined to exercise the sticky accumulator.
module tb_alu_driver;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [4:0]  out_flags;
  logic        busy;
`ifdef ALU_DRV_STICKY_EN
  logic        clr_sticky;
  logic [1:0]  sticky_flags;
`endif

  int asserts;
  int failures;

  alu_driver #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_flags    (out_flags),
`ifdef ALU_DRV_STICKY_EN
    .clr_sticky   (clr_sticky),
    .sticky_flags (sticky_flags),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; in_x = 16'h1234; in_y = 16'h4321; out_ready = 1'b0;
`ifdef ALU_DRV_STICKY_EN
    clr_sticky = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    asserts++; if (out_sum !== 16'h0000) begin failures++; $display("FAIL reset_sum: got %h expected 0000", out_sum); end
    asserts++; if (out_flags !== 5'b00000) begin failures++; $display("FAIL reset_flags: got %b expected 00000", out_flags); end
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    asserts++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef ALU_DRV_STICKY_EN
    asserts++; if (sticky_flags !== 2'b00) begin failures++; $display("FAIL reset_sticky: got %b expected 00", sticky_flags); end
`endif
    $display("txn reset: out_valid=%b out_sum=%h busy=%b", out_valid, out_sum, busy);
  endtask

  // 8fff + 8000 = 1_0fff: carry, signed overflow, 12 ones -> even parity.
  task automatic test_carry_ovf;
    in_x = 16'h8fff; in_y = 16'h8000; in_valid = 1'b1; out_ready = 1'b0;
    asserts++; if (in_ready !== 1'b1) begin failures++; $display("FAIL cov_in_ready_idle: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0; in_x = 16'hffff; in_y = 16'hffff;
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL cov_valid_edge1: got %b expected 0", out_valid); end
    asserts++; if (in_ready !== 1'b0) begin failures++; $display("FAIL cov_in_ready_eval: got %b expected 0", in_ready); end
    asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL cov_busy_eval: got %b expected 1", busy); end
    tick();
    asserts++; if (out_valid !== 1'b1) begin failures++; $display("FAIL cov_valid_edge2: got %b expected 1", out_valid); end
    asserts++; if (out_sum !== 16'h0fff) begin failures++; $display("FAIL cov_sum: got %h expected 0fff", out_sum); end
    asserts++; if (out_flags !== 5'b11100) begin failures++; $display("FAIL cov_flags: got %b expected 11100", out_flags); end
    $display("txn carry_ovf: 8fff+8000 -> sum=%h flags=%b", out_sum, out_flags);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL cov_valid_drop: got %b expected 0", out_valid); end
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL cov_busy_idle: got %b expected 0", busy); end
  endtask

  // 8000 + 8000 = 1_0000: zero, carry, overflow, zero ones -> even parity.
  task automatic test_zero;
    in_x = 16'h8000; in_y = 16'h8000; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    asserts++; if (out_valid !== 1'b1) begin failures++; $display("FAIL zero_valid: got %b expected 1", out_valid); end
    asserts++; if (out_sum !== 16'h0000) begin failures++; $display("FAIL zero_sum: got %h expected 0000", out_sum); end
    asserts++; if (out_flags !== 5'b11110) begin failures++; $display("FAIL zero_flags: got %b expected 11110", out_flags); end
    $display("txn zero: 8000+8000 -> sum=%h flags=%b", out_sum, out_flags);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // 8000 + 0000 held by back-pressure: sign set, odd parity, no carry/ovf.
  task automatic test_stall;
    in_x = 16'h8000; in_y = 16'h0000; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      in_x = 16'h1111 * i[15:0]; in_y = 16'h7777; in_valid = i[0];
      asserts++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, out_valid); end
      asserts++; if (out_sum !== 16'h8000) begin failures++; $display("FAIL stall_sum[%0d]: got %h expected 8000", i, out_sum); end
      asserts++; if (out_flags !== 5'b00001) begin failures++; $display("FAIL stall_flags[%0d]: got %b expected 00001", i, out_flags); end
      asserts++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
      tick();
    end
    $display("txn stall: 8000+0000 -> sum=%h flags=%b", out_sum, out_flags);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_release: busy got %b expected 0", busy); end
  endtask

  // A = 0001+0001 -> 0002 flags 00000; B = 7fff+0001 -> 8000 flags 10001.
  task automatic test_back_to_back;
    in_x = 16'h0001; in_y = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_x = 16'h7fff; in_y = 16'h0001;
    asserts++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_eval_ready: got %b expected 0", in_ready); end
    tick();
    asserts++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_a_valid: got %b expected 1", out_valid); end
    asserts++; if (out_sum !== 16'h0002) begin failures++; $display("FAIL b2b_a_sum: got %h expected 0002", out_sum); end
    asserts++; if (out_flags !== 5'b00000) begin failures++; $display("FAIL b2b_a_flags: got %b expected 00000", out_flags); end
    asserts++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_hold_ready: got %b expected 1", in_ready); end
    $display("txn b2b_a: 0001+0001 -> sum=%h flags=%b", out_sum, out_flags);
    tick();
    in_valid = 1'b0;
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap_valid: got %b expected 0", out_valid); end
    asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_gap_busy: got %b expected 1", busy); end
    tick();
    asserts++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_b_valid: got %b expected 1", out_valid); end
    asserts++; if (out_sum !== 16'h8000) begin failures++; $display("FAIL b2b_b_sum: got %h expected 8000", out_sum); end
    asserts++; if (out_flags !== 5'b10001) begin failures++; $display("FAIL b2b_b_flags: got %b expected 10001", out_flags); end
    $display("txn b2b_b: 7fff+0001 -> sum=%h flags=%b", out_sum, out_flags);
    tick();
    out_ready = 1'b0;
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_reset_in_eval;
    in_x = 16'h8fff; in_y = 16'h8000; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_eval_valid: got %b expected 0", out_valid); end
    asserts++; if (out_sum !== 16'h0000) begin failures++; $display("FAIL rst_eval_sum: got %h expected 0000", out_sum); end
    asserts++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_eval_ready: got %b expected 1", in_ready); end
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_eval_busy: got %b expected 0", busy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_eval_stale[%0d]: got %b expected 0", i, out_valid); end
    end
    out_ready = 1'b0;
    $display("txn reset_in_eval: out_valid=%b out_sum=%h", out_valid, out_sum);
  endtask

`ifdef ALU_DRV_STICKY_EN
  task automatic test_sticky;
    in_x = 16'h8000; in_y = 16'h8000; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_x = 16'h0001; in_y = 16'h0001;
    tick();
    asserts++; if (sticky_flags !== 2'b11) begin failures++; $display("FAIL sticky_set: got %b expected 11", sticky_flags); end
    $display("txn sticky_a: 8000+8000 -> sticky=%b", sticky_flags);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    asserts++; if (sticky_flags !== 2'b11) begin failures++; $display("FAIL sticky_keep: got %b expected 11", sticky_flags); end
    $display("txn sticky_b: 0001+0001 -> sticky=%b", sticky_flags);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    asserts++; if (sticky_flags !== 2'b00) begin failures++; $display("FAIL sticky_clear: got %b expected 00", sticky_flags); end
    // Clear during EVAL: the new result's {ovf, carry} = {0,1} wins.
    in_x = 16'hffff; in_y = 16'h0001; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    asserts++; if (sticky_flags !== 2'b01) begin failures++; $display("FAIL sticky_clr_same: got %b expected 01", sticky_flags); end
    $display("txn sticky_c: ffff+0001 with clear -> sticky=%b", sticky_flags);
    tick();
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    asserts = 0;
    failures = 0;
    rst = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0;
`ifdef ALU_DRV_STICKY_EN
    clr_sticky = 1'b0;
`endif
    tick();
    test_reset();
    test_carry_ovf();
    test_zero();
    test_stall();
    test_back_to_back();
    test_reset_in_eval();
`ifdef ALU_DRV_STICKY_EN
    test_sticky();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; only 16 is supported with the existing alu.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  driver can accept an operand pair this cycle.
REQ-006 in_x  input  WIDTH  first operand.
REQ-007 in_y  input  WIDTH  second operand.
REQ-008 out_valid  output  1  result and flags are valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_sum  output  WIDTH  registered sum x+y, modulo 2^WIDTH.
REQ-011 out_flags  output  5  registered {overflow, parity, carry, zero, sign}.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The driver SHALL use three states: IDLE, EVAL and HOLD.
REQ-014 IDLE: in_ready=1; on in_valid&&in_ready, latch in_x/in_y into the operand registers and go to EVAL.
REQ-015 EVAL: in_ready=0; operand registers drive one alu instance; at the end of the cycle latch sum and flags into the result registers, set out_valid=1 and go to HOLD.
REQ-016 HOLD: out_valid=1; out_sum/out_flags SHALL stay stable until out_valid&&out_ready.
REQ-017 HOLD: in_ready SHALL equal out_ready.
REQ-018 HOLD with out_ready=1 and in_valid=1: complete the output handshake, latch new operands and go to EVAL in the same edge (back-to-back).
REQ-019 HOLD with out_ready=1 and in_valid=0: go to IDLE and clear out_valid.
REQ-020 Latency SHALL be exactly 2 edges from input handshake to out_valid=1 when the input handshake occurs in IDLE; sustained throughput is one result per 2 cycles.
REQ-021 Flag rules:
- sign = sum[WIDTH-1]
- zero = (sum==0)
- carry = carry out of the unsigned add
- parity = 1 when sum has an even number of ones
- overflow = 1 when operand signs are equal and differ from the sum sign
REQ-022 in_x/in_y changes while in_ready=0 SHALL have no effect.

Reset
REQ-023 When rst=1 at a clock edge, the driver SHALL go to IDLE and clear all of the following to 0: out_valid, out_sum, out_flags, operand registers and busy.
REQ-024 Reset SHALL take priority over any handshake in the same cycle; a result in EVAL or HOLD is discarded.
REQ-025 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-026 With ALU_DRV_STICKY_EN defined, the driver SHALL add input clr_sticky (1) and output sticky_flags (2, {overflow, carry}).
REQ-027 sticky_flags SHALL OR in the carry and overflow of every result at its EVAL->HOLD edge.
REQ-028 clr_sticky=1 SHALL clear sticky_flags at the next edge; if a result is latched in the same cycle, that result's carry/overflow SHALL be the new sticky_flags value.
REQ-029 rst SHALL also clear sticky_flags.
REQ-030 Without ALU_DRV_STICKY_EN, neither port nor the accumulator logic SHALL exist.

Structure
REQ-031 Package alu_pkg SHALL hold WIDTH_DEFAULT=16, the flag bit indices (SIGN=0, ZERO=1, CARRY=2, PARITY=3, OVF=4) and the state enum.
REQ-032 The existing combinational alu SHALL be the only sub-module, instantiated once; the driver SHALL contain no arithmetic of its own.

Verification
REQ-033 Input 8fff+8000 -> out_sum 0fff, flags sign0 zero0 carry1 parity1 ovf1, out_valid 2 edges after the handshake.
REQ-034 Input 8000+8000 -> out_sum 0000, zero1 carry1 ovf1 parity1 sign0.
REQ-035 Input 8000+0000 with out_ready held 0 for 5 cycles -> out_sum 8000, sign1 parity0 carry0 ovf0; outputs stable throughout; in_ready=0 for those cycles.
REQ-036 Back-to-back: two pairs with in_valid and out_ready held 1 -> second input handshake on the same edge as the first output handshake; results in order.
REQ-037 rst pulsed during EVAL -> next cycle out_valid=0, out_sum=0000, in_ready=1, and no stale result appears.
REQ-038 With ALU_DRV_STICKY_EN: 8000+8000 then 0001+0001 -> sticky_flags=11; clr_sticky for 1 cycle -> 00.
